// File: rtl/axi_wr_sched_pkg.sv
// Shared types and constants for the output write-job scheduler.
package axi_wr_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RETIRE    = 3'd4
    } sched_state_e;

    localparam int DESC_PTR_W  = 64;
    localparam int DESC_SIZE_W = 32;

    // Descriptor layout at the default widths; the FIFO stores {ptr, size} in this order.
    typedef struct packed {
        logic [DESC_PTR_W-1:0]  ptr;
        logic [DESC_SIZE_W-1:0] size;
    } desc_t;

    localparam int PERF_BUSY_W = 32;
    localparam int PERF_JOBS_W = 16;

endpackage

// File: rtl/axi_wr_desc_fifo.sv
// Synchronous register FIFO for write descriptors; wrap-flag pointers give full/empty/level.
module axi_wr_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/axi_wr_job_sched.sv
// Output write-job scheduler: queues descriptors and runs one write-path job at a time.
// Define AXI_WR_SCHED_PERF_EN to build the busy-cycle and job performance counters.
module axi_wr_job_sched
    import axi_wr_sched_pkg::*;
#(
    parameter int DEPTH               = 4,
    parameter int AXI_ADDR_WIDTH      = 64,
    parameter int AXI_XFER_SIZE_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_desc_valid,
    output logic                           o_desc_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]      i_desc_ptr,
    input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_desc_size,
    output logic                           o_axiwr_start,
    input  logic                           i_axiwr_done,
    output logic [AXI_ADDR_WIDTH-1:0]      o_data_ptr,
    output logic [AXI_XFER_SIZE_WIDTH-1:0] o_data_size_bytes,
    output logic                           o_cmpl_valid,
    output logic                           o_cmpl_zero,
    output logic                           o_busy,
    output logic [$clog2(DEPTH):0]         o_level,
    output logic [PERF_BUSY_W-1:0]         o_perf_busy_cycles,
    output logic [PERF_JOBS_W-1:0]         o_perf_jobs
);

    localparam int DW = AXI_ADDR_WIDTH + AXI_XFER_SIZE_WIDTH;

    sched_state_e                   state;
    logic [DW-1:0]                  head;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic                           fifo_pop;
    logic [AXI_ADDR_WIDTH-1:0]      head_ptr;
    logic [AXI_XFER_SIZE_WIDTH-1:0] head_size;

    axi_wr_desc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (i_desc_valid),
        .wdata ({i_desc_ptr, i_desc_size}),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_level)
    );

    assign head_ptr     = head[DW-1:AXI_XFER_SIZE_WIDTH];
    assign head_size    = head[AXI_XFER_SIZE_WIDTH-1:0];
    assign fifo_pop     = (state == ST_IDLE) && !fifo_empty;
    assign o_desc_ready = !fifo_full;
    assign o_busy       = !fifo_empty || (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            o_data_ptr        <= '0;
            o_data_size_bytes <= '0;
            o_axiwr_start     <= 1'b0;
            o_cmpl_valid      <= 1'b0;
            o_cmpl_zero       <= 1'b0;
        end else begin
            o_axiwr_start <= 1'b0;
            o_cmpl_valid  <= 1'b0;
            o_cmpl_zero   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        o_data_ptr        <= head_ptr;
                        o_data_size_bytes <= head_size;
                        if (head_size == '0) begin
                            state        <= ST_RETIRE;
                            o_cmpl_valid <= 1'b1;
                            o_cmpl_zero  <= 1'b1;
                        end else begin
                            state         <= ST_LAUNCH;
                            o_axiwr_start <= 1'b1;
                        end
                    end
                end
                ST_LAUNCH:    state <= ST_WAIT_BUSY;
                // done is still high from the previous idle period; only its fall proves acceptance
                ST_WAIT_BUSY: if (!i_axiwr_done) state <= ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (i_axiwr_done) begin
                        state        <= ST_RETIRE;
                        o_cmpl_valid <= 1'b1;
                    end
                end
                ST_RETIRE:    state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

`ifdef AXI_WR_SCHED_PERF_EN
    logic [PERF_BUSY_W-1:0] perf_busy;
    logic [PERF_JOBS_W-1:0] perf_jobs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_busy <= '0;
            perf_jobs <= '0;
        end else begin
            if ((state == ST_LAUNCH || state == ST_WAIT_BUSY || state == ST_WAIT_DONE)
                && perf_busy != '1)
                perf_busy <= perf_busy + PERF_BUSY_W'(1);
            if (state == ST_RETIRE && !o_cmpl_zero && perf_jobs != '1)
                perf_jobs <= perf_jobs + PERF_JOBS_W'(1);
        end
    end

    assign o_perf_busy_cycles = perf_busy;
    assign o_perf_jobs        = perf_jobs;
`else
    assign o_perf_busy_cycles = '0;
    assign o_perf_jobs        = '0;
`endif

endmodule

// File: tb/tb_axi_wr_job_sched.sv
// Directed bench for axi_wr_job_sched with a behavioural write-path model and completion monitor.
module tb_axi_wr_job_sched;

    logic        clk;
    logic        rst_n;
    logic        i_desc_valid;
    logic        o_desc_ready;
    logic [63:0] i_desc_ptr;
    logic [31:0] i_desc_size;
    logic        o_axiwr_start;
    logic        i_axiwr_done;
    logic [63:0] o_data_ptr;
    logic [31:0] o_data_size_bytes;
    logic        o_cmpl_valid;
    logic        o_cmpl_zero;
    logic        o_busy;
    logic [2:0]  o_level;
    logic [31:0] o_perf_busy_cycles;
    logic [15:0] o_perf_jobs;

    int n_checks = 0;
    int n_fail   = 0;

    // write-path model knobs
    int wp_hold  = 1;
    int wp_busy  = 50;
    bit wp_stall = 0;

    // monitor state
    int          n_start = 0;
    int          n_cmpl  = 0;
    logic [63:0] q_ptr[$];
    logic        q_zero[$];

    axi_wr_job_sched dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_desc_valid       (i_desc_valid),
        .o_desc_ready       (o_desc_ready),
        .i_desc_ptr         (i_desc_ptr),
        .i_desc_size        (i_desc_size),
        .o_axiwr_start      (o_axiwr_start),
        .i_axiwr_done       (i_axiwr_done),
        .o_data_ptr         (o_data_ptr),
        .o_data_size_bytes  (o_data_size_bytes),
        .o_cmpl_valid       (o_cmpl_valid),
        .o_cmpl_zero        (o_cmpl_zero),
        .o_busy             (o_busy),
        .o_level            (o_level),
        .o_perf_busy_cycles (o_perf_busy_cycles),
        .o_perf_jobs        (o_perf_jobs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write path: done drops wp_hold cycles after start, rises again wp_busy cycles later.
    initial begin
        i_axiwr_done = 1'b1;
        forever begin
            tick();
            if (o_axiwr_start) begin
                repeat (wp_hold) tick();
                i_axiwr_done = 1'b0;
                repeat (wp_busy) tick();
                while (wp_stall) tick();
                i_axiwr_done = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (o_axiwr_start) n_start++;
            if (o_cmpl_valid) begin
                q_ptr.push_back(o_data_ptr);
                q_zero.push_back(o_cmpl_zero);
                n_cmpl++;
            end
        end
    end

    task automatic push(input logic [63:0] ptr, input logic [31:0] size);
        i_desc_valid = 1'b1;
        i_desc_ptr   = ptr;
        i_desc_size  = size;
        tick();
        i_desc_valid = 1'b0;
    endtask

    task automatic wait_cmpl(input int max, input logic [63:0] exp_ptr,
                             output int n, output bit stable);
        n = 0;
        stable = 1'b1;
        while (!o_cmpl_valid && n < max) begin
            tick();
            n++;
            if (o_data_ptr !== exp_ptr) stable = 1'b0;
        end
    endtask

    task automatic wait_count(input string tag, input int target, input int max);
        int k = 0;
        while (n_cmpl < target && k < max) begin
            tick();
            k++;
        end
        chk(tag, 64'(n_cmpl), 64'(target));
    endtask

    task automatic expect_cmpl(input string tag, input logic [63:0] ptr, input logic zero);
        chk({tag, "_present"}, 64'(q_ptr.size() != 0), 64'd1);
        if (q_ptr.size() != 0) begin
            chk({tag, "_ptr"}, q_ptr.pop_front(), ptr);
            chk({tag, "_zero"}, 64'(q_zero.pop_front()), 64'(zero));
        end
    endtask

    initial begin
        int  n;
        bit  stable;
        int  s0;
        int  c0;

        rst_n        = 1'b0;
        i_desc_valid = 1'b0;
        i_desc_ptr   = '0;
        i_desc_size  = '0;
        repeat (3) tick();

        chk("rst_ready", 64'(o_desc_ready), 64'd1);
        chk("rst_level", 64'(o_level), 64'd0);
        chk("rst_busy",  64'(o_busy), 64'd0);
        chk("rst_start", 64'(o_axiwr_start), 64'd0);
        chk("rst_cmpl",  64'(o_cmpl_valid), 64'd0);
        chk("rst_zero",  64'(o_cmpl_zero), 64'd0);
        chk("rst_ptr",   o_data_ptr, 64'd0);
        chk("rst_size",  64'(o_data_size_bytes), 64'd0);
        chk("rst_pbusy", 64'(o_perf_busy_cycles), 64'd0);
        chk("rst_pjobs", 64'(o_perf_jobs), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single 4 KiB job: start at t+2, done low t+3..t+52, high at t+53, cmpl at t+54.
        s0 = n_start;
        push(64'h1000, 32'd4096);
        chk("t1_level_t1", 64'(o_level), 64'd1);
        chk("t1_start_t1", 64'(o_axiwr_start), 64'd0);
        chk("t1_busy_t1",  64'(o_busy), 64'd1);
        tick();
        chk("t1_start_t2", 64'(o_axiwr_start), 64'd1);
        chk("t1_ptr_t2",   o_data_ptr, 64'h1000);
        chk("t1_size_t2",  64'(o_data_size_bytes), 64'd4096);
        chk("t1_level_t2", 64'(o_level), 64'd0);
        tick();
        chk("t1_start_t3", 64'(o_axiwr_start), 64'd0);
        wait_cmpl(200, 64'h1000, n, stable);
        chk("t1_cmpl_lat", 64'(n), 64'd51);
        chk("t1_ptr_stable", 64'(stable), 64'd1);
        chk("t1_cmpl_zero", 64'(o_cmpl_zero), 64'd0);
        tick();
        chk("t1_cmpl_pulse", 64'(o_cmpl_valid), 64'd0);
        chk("t1_busy_after", 64'(o_busy), 64'd0);
        chk("t1_ptr_held",   o_data_ptr, 64'h1000);
        chk("t1_starts",     64'(n_start - s0), 64'd1);
        expect_cmpl("t1", 64'h1000, 1'b0);

        // Lone zero-size job: pop at u+1, cmpl at u+2, no start.
        s0 = n_start;
        push(64'h3000, 32'd0);
        chk("z_cmpl_u1", 64'(o_cmpl_valid), 64'd0);
        chk("z_ptr_u1",  o_data_ptr, 64'h1000);
        tick();
        chk("z_cmpl_u2", 64'(o_cmpl_valid), 64'd1);
        chk("z_zero_u2", 64'(o_cmpl_zero), 64'd1);
        chk("z_ptr_u2",  o_data_ptr, 64'h3000);
        chk("z_size_u2", 64'(o_data_size_bytes), 64'd0);
        tick();
        chk("z_cmpl_u3", 64'(o_cmpl_valid), 64'd0);
        chk("z_busy_u3", 64'(o_busy), 64'd0);
        chk("z_starts",  64'(n_start - s0), 64'd0);
        expect_cmpl("z", 64'h3000, 1'b1);

        // Zero-size job between two 64-byte jobs.
        wp_busy = 5;
        s0 = n_start;
        c0 = n_cmpl;
        push(64'h2000, 32'd64);
        push(64'h3100, 32'd0);
        push(64'h4000, 32'd64);
        wait_count("azb_count", c0 + 3, 300);
        chk("azb_starts", 64'(n_start - s0), 64'd2);
        expect_cmpl("azb_a", 64'h2000, 1'b0);
        expect_cmpl("azb_z", 64'h3100, 1'b1);
        expect_cmpl("azb_b", 64'h4000, 1'b0);

        // Fill: five back-to-back pushes with a stalled write path -> one active, four queued.
        wp_stall = 1'b1;
        wp_busy  = 2;
        c0 = n_cmpl;
        for (int k = 0; k < 5; k++) push(64'(k) << 8, 32'd64);
        chk("fill_level", 64'(o_level), 64'd4);
        chk("fill_ready", 64'(o_desc_ready), 64'd0);
        chk("fill_busy",  64'(o_busy), 64'd1);
        i_desc_valid = 1'b1;
        i_desc_ptr   = 64'h500;
        i_desc_size  = 32'd64;
        repeat (10) tick();
        chk("fill_refused_ready", 64'(o_desc_ready), 64'd0);
        chk("fill_refused_level", 64'(o_level), 64'd4);
        chk("fill_no_cmpl", 64'(n_cmpl - c0), 64'd0);
        wp_stall = 1'b0;
        n = 0;
        while (!o_cmpl_valid && n < 100) begin
            tick();
            n++;
        end
        chk("fill_first_cmpl", 64'(o_cmpl_valid), 64'd1);
        chk("fill_ready_r0", 64'(o_desc_ready), 64'd0);
        tick();
        chk("fill_ready_r1", 64'(o_desc_ready), 64'd0);
        chk("fill_level_r1", 64'(o_level), 64'd4);
        tick();
        chk("fill_ready_r2", 64'(o_desc_ready), 64'd1);
        chk("fill_level_r2", 64'(o_level), 64'd3);
        tick();
        i_desc_valid = 1'b0;
        chk("fill_level_r3", 64'(o_level), 64'd4);
        chk("fill_ready_r3", 64'(o_desc_ready), 64'd0);
        wait_count("fill_count", c0 + 6, 2000);
        for (int k = 0; k < 6; k++) expect_cmpl("fill_order", 64'(k) << 8, 1'b0);

        // done held high 3 cycles past start: WAIT_BUSY must not retire early; cmpl at t+10.
        wp_hold = 4;
        wp_busy = 3;
        push(64'h6000, 32'd128);
        tick();
        chk("hold_start", 64'(o_axiwr_start), 64'd1);
        tick();
        wait_cmpl(100, 64'h6000, n, stable);
        chk("hold_cmpl_lat", 64'(n), 64'd7);
        tick();
        expect_cmpl("hold", 64'h6000, 1'b0);

        // Reset in WAIT_DONE with two queued jobs.
        wp_hold  = 1;
        wp_busy  = 1;
        wp_stall = 1'b1;
        c0 = n_cmpl;
        s0 = n_start;
        push(64'h7000, 32'd64);
        push(64'h7100, 32'd64);
        push(64'h7200, 32'd64);
        repeat (3) tick();
        chk("rj_level", 64'(o_level), 64'd2);
        chk("rj_busy",  64'(o_busy), 64'd1);
        chk("rj_start", 64'(n_start - s0), 64'd1);
        rst_n    = 1'b0;
        wp_stall = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rj_ready", 64'(o_desc_ready), 64'd1);
        chk("rj_level0", 64'(o_level), 64'd0);
        chk("rj_busy0", 64'(o_busy), 64'd0);
        chk("rj_ptr0",  o_data_ptr, 64'd0);
        chk("rj_size0", 64'(o_data_size_bytes), 64'd0);
        chk("rj_cmplv", 64'(o_cmpl_valid), 64'd0);
        chk("rj_startv", 64'(o_axiwr_start), 64'd0);
        repeat (20) tick();
        chk("rj_no_cmpl",  64'(n_cmpl - c0), 64'd0);
        chk("rj_no_start", 64'(n_start - s0), 64'd1);
        chk("rj_pbusy", 64'(o_perf_busy_cycles), 64'd0);

        // Perf: two 50-busy-cycle jobs (LAUNCH + WAIT_BUSY + 48 WAIT_DONE) around a zero job.
        wp_busy = 48;
        c0 = n_cmpl;
        push(64'h8000, 32'd256);
        push(64'h8100, 32'd0);
        push(64'h9000, 32'd256);
        wait_count("perf_count", c0 + 3, 500);
        tick();
        tick();
        expect_cmpl("perf_a", 64'h8000, 1'b0);
        expect_cmpl("perf_z", 64'h8100, 1'b1);
        expect_cmpl("perf_b", 64'h9000, 1'b0);
`ifdef AXI_WR_SCHED_PERF_EN
        chk("perf_busy_cycles", 64'(o_perf_busy_cycles), 64'd100);
        chk("perf_jobs",        64'(o_perf_jobs), 64'd2);
`else
        chk("perf_busy_tied", 64'(o_perf_busy_cycles), 64'd0);
        chk("perf_jobs_tied", 64'(o_perf_jobs), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
